select_scan: RTL and testbench

Sequential read-out engine for the `select` register file: it sits directly downstream of the memory, drives its `read_adr` port and consumes its combinational `read_data`. On a start command it walks a contiguous, wrap-around address window and emits one entry per cycle on a valid/ready stream, applying back-pressure by holding the address. It is used to serialise memory contents into the next garbled-circuit stage without a separate address counter.

---
 rtl/select_scan.sv | 115 +++++++++++
 tb/tb_select_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/select_scan.sv
// Sequential read-out engine: walks a wrap-around address window of the select
// memory and streams entries on valid/ready. Optional running max: SELECT_SCAN_MAX_EN.
module select_scan #(
  parameter  int M    = 128,
  parameter  int W    = 7,
  localparam int LOGM = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LOGM-1:0] base_adr,
  input  logic [LOGM:0]   count,
  output logic            busy,
  output logic            done,
  output logic [LOGM-1:0] read_adr,
  input  logic [W-1:0]    read_data,
  output logic [W-1:0]    out_data,
  output logic [LOGM-1:0] out_adr,
  output logic            out_valid,
  input  logic            out_ready
`ifdef SELECT_SCAN_MAX_EN
  ,
  output logic [W-1:0]    max_data,
  output logic [LOGM-1:0] max_adr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [LOGM-1:0] r_cur;
  logic [LOGM:0]   r_rem;
  logic [W-1:0]    r_out_data;
  logic [LOGM-1:0] r_out_adr;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_load;
  logic [LOGM:0]   w_cnt_clamped;
  logic [LOGM-1:0] w_cur_inc;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_load        = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_cnt_clamped = (count > (LOGM+1)'(M)) ? (LOGM+1)'(M) : count;
  assign w_cur_inc     = (r_cur == LOGM'(M-1)) ? '0 : r_cur + LOGM'(1);

  // DRAIN first retires the last handshake, then spends one cycle with
  // out_valid low before DONE, giving done two cycles after the last entry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (w_cnt_clamped == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_load && (r_rem == (LOGM+1)'(1))) w_next = S_DRAIN;
      S_DRAIN: if (!r_out_valid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_adr   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cur <= base_adr;
        r_rem <= w_cnt_clamped;
      end
      if (w_load) begin
        r_out_data  <= read_data;
        r_out_adr   <= r_cur;
        r_out_valid <= 1'b1;
        r_cur       <= w_cur_inc;
        r_rem       <= r_rem - (LOGM+1)'(1);
      end
      if ((r_state == S_DRAIN) && r_out_valid && out_ready)
        r_out_valid <= 1'b0;
    end
  end

`ifdef SELECT_SCAN_MAX_EN
  logic [W-1:0]    r_max_data;
  logic [LOGM-1:0] r_max_adr;

  // Strict greater-than keeps the earliest address on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_data <= '0;
      r_max_adr  <= '0;
    end else if (w_accept) begin
      r_max_data <= '0;
      r_max_adr  <= '0;
    end else if (w_load && (read_data > r_max_data)) begin
      r_max_data <= read_data;
      r_max_adr  <= r_cur;
    end
  end

  assign max_data = r_max_data;
  assign max_adr  = r_max_adr;
`endif

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign read_adr  = r_cur;
  assign out_data  = r_out_data;
  assign out_adr   = r_out_adr;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_select_scan.sv
// Directed self-checking bench for select_scan, with a behavioural memory
// driving read_data combinationally from read_adr.
module tb_select_scan;
  localparam int M = 128;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [6:0]   base_adr;
  logic [7:0]   count;
  logic         busy, done, out_valid;
  logic [6:0]   read_adr, out_adr;
  logic [W-1:0] read_data, out_data;
`ifdef SELECT_SCAN_MAX_EN
  logic [W-1:0] max_data;
  logic [6:0]   max_adr;
`endif

  logic [W-1:0] mem [M];
  assign read_data = mem[read_adr];

  int passed = 0;
  int total  = 0;

  select_scan #(.M(M), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .count(count),
    .busy(busy), .done(done), .read_adr(read_adr), .read_data(read_data),
    .out_data(out_data), .out_adr(out_adr), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SELECT_SCAN_MAX_EN
    , .max_data(max_data), .max_adr(max_adr)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Full scan with out_ready high; poke pulses start while busy and in DONE.
  task automatic scan(input int base, input int cnt, input bit poke);
    int n;
    int a;
    n = (cnt > M) ? M : cnt;
    start = 1'b1; base_adr = 7'(base); count = 8'(cnt); out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_read_adr", read_adr, 32'(base));
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", out_valid, 0);
      tick();
      chk("zero_done_end", done, 0);
      chk("zero_idle", busy, 0);
      return;
    end
    chk("first_nvalid", out_valid, 0);
    chk("first_ndone", done, 0);
    for (int j = 0; j < n; j++) begin
      if (poke && j == 1) begin
        start = 1'b1; base_adr = 7'd100; count = 8'd2;
      end
      tick();
      start = 1'b0;
      a = (base + j) % M;
      chk("ent_valid", out_valid, 1);
      chk("ent_adr", out_adr, 32'(a));
      chk("ent_data", out_data, 32'(mem[a]));
      chk("ent_ndone", done, 0);
    end
    tick();
    chk("drain_nvalid", out_valid, 0);
    chk("drain_ndone", done, 0);
    chk("drain_busy", busy, 1);
    tick();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    chk("after_ndone", done, 0);
    chk("after_idle", busy, 0);
    if (poke) begin
      tick();
      chk("poke_idle", busy, 0);
      chk("poke_nvalid", out_valid, 0);
    end
  endtask

  initial begin
    bit           pv, pr, seen_done;
    int           got;
    logic [6:0]   hadr, hra;
    logic [W-1:0] hdat;

    for (int i = 0; i < M; i++) mem[i] = W'(i);
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_adr = '0; count = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read_adr", read_adr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_adr", out_adr, 0);
    chk("rst_out_valid", out_valid, 0);
`ifdef SELECT_SCAN_MAX_EN
    chk("rst_max_data", max_data, 0);
    chk("rst_max_adr", max_adr, 0);
`endif
    rst = 1'b0;
    tick();

    scan(5, 4, 0);
    scan(126, 4, 0);
    scan(0, 200, 0);

    // Stalling: out_ready pattern 1,0,0,1 over a 6-entry scan from 20.
    start = 1'b1; base_adr = 7'd20; count = 8'd6; out_ready = 1'b0;
    tick();
    start = 1'b0;
    got = 0; seen_done = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      pv = out_valid; pr = out_ready;
      hadr = out_adr; hdat = out_data; hra = read_adr;
      if (pv && pr) begin
        chk("stall_adr", out_adr, 32'((20 + got) % M));
        chk("stall_data", out_data, 32'(mem[(20 + got) % M]));
        got++;
      end
      tick();
      if (pv && !pr) begin
        chk("hold_adr", out_adr, 32'(hadr));
        chk("hold_data", out_data, 32'(hdat));
        chk("hold_read_adr", read_adr, 32'(hra));
        chk("hold_valid", out_valid, 1);
      end
      if (done) seen_done = 1;
    end
    chk("stall_count", got, 6);
    chk("stall_done_seen", seen_done, 1);
    out_ready = 1'b1;
    tick();

    scan(50, 0, 0);
    scan(5, 4, 1);

    // Reset mid-scan drops everything with no done pulse.
    start = 1'b1; base_adr = 7'd0; count = 8'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_valid_pre", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_read_adr", read_adr, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_adr", out_adr, 0);
    chk("mrst_out_valid", out_valid, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mrst_no_done", done, 0);
      chk("mrst_stay_idle", busy, 0);
    end

`ifdef SELECT_SCAN_MAX_EN
    mem[10] = 7'd3; mem[11] = 7'd9; mem[12] = 7'd9; mem[13] = 7'd2;
    scan(10, 4, 0);
    chk("max_data", max_data, 9);
    chk("max_adr", max_adr, 11);
    scan(60, 0, 0);
    chk("max_zero_data", max_data, 0);
    chk("max_zero_adr", max_adr, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
